multicycle_sequencer: RTL and testbench

Control FSM for the RV32I multicycle core. It steps each instruction through fetch, decode, execute, memory and writeback. At each step it drives the datapath load enables and mux selects, including the SrcB select that routes the immediate generator output into the ALU. It stalls on the memory handshake, counts retired instructions, and halts on EBREAK or an illegal opcode.

---
 rtl/seq_pkg.sv | 50 +++++
 rtl/op_classify.sv | 36 +++
 rtl/multicycle_sequencer.sv | 147 ++++++++++++++
 tb/tb_multicycle_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// ============================================================================
// seq_pkg
// Shared types and constants for the RV32I multicycle sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  localparam logic [6:0] RTYPE   = 7'b0110011;
  localparam logic [6:0] ITYPE   = 7'b0010011;
  localparam logic [6:0] ITYPE_L = 7'b0000011;
  localparam logic [6:0] ITYPE_J = 7'b1100111;
  localparam logic [6:0] ITYPE_E = 7'b1110011;
  localparam logic [6:0] STYPE   = 7'b0100011;
  localparam logic [6:0] BTYPE   = 7'b1100011;
  localparam logic [6:0] UTYPE_L = 7'b0110111;
  localparam logic [6:0] UTYPE_A = 7'b0010111;
  localparam logic [6:0] JTYPE   = 7'b1101111;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  typedef struct packed {
    logic r;
    logic i_alu;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic system;
  } op_class_t;

endpackage

`default_nettype wire

// File: rtl/op_classify.sv
// ============================================================================
// op_classify
// Combinational opcode decoder: one-hot instruction class plus illegal flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module op_classify
  import seq_pkg::*;
(
  input  logic [6:0] i_opcode,
  output op_class_t  o_class,
  output logic       o_illegal
);

  always_comb begin
    o_class   = '0;
    o_illegal = 1'b0;
    case (i_opcode)
      RTYPE:   o_class.r      = 1'b1;
      ITYPE:   o_class.i_alu  = 1'b1;
      ITYPE_L: o_class.load   = 1'b1;
      STYPE:   o_class.store  = 1'b1;
      BTYPE:   o_class.branch = 1'b1;
      JTYPE:   o_class.jal    = 1'b1;
      ITYPE_J: o_class.jalr   = 1'b1;
      UTYPE_L: o_class.lui    = 1'b1;
      UTYPE_A: o_class.auipc  = 1'b1;
      ITYPE_E: o_class.system = 1'b1;
      default: o_illegal      = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_sequencer.sv
// ============================================================================
// multicycle_sequencer
// Control FSM stepping RV32I instructions through fetch/decode/execute/mem/wb.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [DATA_WIDTH-1:0] ir_i,
  input  logic                  mem_ready_i,
  input  logic                  branch_taken_i,
  output logic                  ir_ld_o,
  output logic                  pc_ld_o,
  output logic                  pc_src_o,
  output logic                  addr_src_o,
  output logic                  mem_rd_o,
  output logic                  mem_wr_o,
  output logic                  a_src_o,
  output logic                  b_src_o,
  output logic                  rf_wr_o,
  output logic [1:0]            wd_src_o,
  output logic                  halted_o,
  output logic [2:0]            state_o,
  output logic [DATA_WIDTH-1:0] retired_o
);

  state_t                r_state;
  state_t                w_next;
  op_class_t             w_class;
  logic                  w_illegal;
  logic                  w_ebreak;
  logic                  w_retire;
  logic                  w_unused_ir;
  logic [DATA_WIDTH-1:0] r_retired;

  op_classify u_classify (
    .i_opcode  (ir_i[6:0]),
    .o_class   (w_class),
    .o_illegal (w_illegal)
  );

  assign w_ebreak    = w_class.system && (ir_i[31:20] == 12'd1) && (ir_i[14:12] == 3'd0);
  assign w_unused_ir = ^{ir_i[19:15], ir_i[11:7]};

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state   <= S_RESET;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + DATA_WIDTH'(1);
    end
  end

  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    ir_ld_o    = 1'b0;
    pc_ld_o    = 1'b0;
    pc_src_o   = 1'b0;
    addr_src_o = 1'b0;
    mem_rd_o   = 1'b0;
    mem_wr_o   = 1'b0;
    a_src_o    = 1'b0;
    b_src_o    = 1'b0;
    rf_wr_o    = 1'b0;
    wd_src_o   = WD_ALU;
    halted_o   = 1'b0;
    case (r_state)
      S_RESET: w_next = S_FETCH;
      S_FETCH: begin
        mem_rd_o = 1'b1;
        if (mem_ready_i) begin
          ir_ld_o = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_illegal || w_ebreak) w_next = S_HALT;
        else if (w_class.system)   w_next = S_WB;
        else                       w_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (w_class.r) begin
          w_next = S_WB;
        end else if (w_class.i_alu || w_class.jalr || w_class.lui) begin
          b_src_o = 1'b1;
          w_next  = S_WB;
        end else if (w_class.load || w_class.store) begin
          b_src_o = 1'b1;
          w_next  = S_MEM;
        end else if (w_class.auipc || w_class.jal) begin
          a_src_o = 1'b1;
          b_src_o = 1'b1;
          w_next  = S_WB;
        end else if (w_class.branch) begin
          // Branches resolve and retire here, skipping writeback entirely.
          a_src_o  = 1'b1;
          b_src_o  = 1'b1;
          pc_ld_o  = 1'b1;
          pc_src_o = branch_taken_i;
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end else begin
          w_next = S_RESET;
        end
      end
      S_MEM: begin
        addr_src_o = 1'b1;
        mem_rd_o   = w_class.load;
        mem_wr_o   = w_class.store;
        if (mem_ready_i) begin
          if (w_class.store) begin
            pc_ld_o  = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        pc_ld_o  = 1'b1;
        rf_wr_o  = !w_class.system;
        pc_src_o = w_class.jal || w_class.jalr;
        if (w_class.load)                    wd_src_o = WD_MEM;
        else if (w_class.jal || w_class.jalr) wd_src_o = WD_PC4;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT:  halted_o = 1'b1;
      default: w_next = S_RESET;
    endcase
  end

  assign state_o   = r_state;
  assign retired_o = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
// ============================================================================
// tb_multicycle_sequencer
// Self-checking bench: per-instruction expected cycle streams vs. the DUT.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_sequencer;

  localparam logic [2:0] ST_RESET = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic [31:0] ir_i = '0;
  logic        mem_ready_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic        ir_ld_o, pc_ld_o, pc_src_o, addr_src_o, mem_rd_o, mem_wr_o;
  logic        a_src_o, b_src_o, rf_wr_o, halted_o;
  logic [1:0]  wd_src_o;
  logic [2:0]  state_o;
  logic [31:0] retired_o;

  multicycle_sequencer #(.DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .ir_i(ir_i), .mem_ready_i(mem_ready_i),
    .branch_taken_i(branch_taken_i), .ir_ld_o(ir_ld_o), .pc_ld_o(pc_ld_o),
    .pc_src_o(pc_src_o), .addr_src_o(addr_src_o), .mem_rd_o(mem_rd_o),
    .mem_wr_o(mem_wr_o), .a_src_o(a_src_o), .b_src_o(b_src_o), .rf_wr_o(rf_wr_o),
    .wd_src_o(wd_src_o), .halted_o(halted_o), .state_o(state_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0] st;
    logic ir_ld, pc_ld, pc_src, addr_src, mem_rd, mem_wr, a_src, b_src, rf_wr;
    logic [1:0] wd;
    logic halted;
  } outs_t;

  typedef struct packed {
    outs_t o;
    logic  rdy;
    logic  ret;
  } cyc_t;

  cyc_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_ret = '0;

  function automatic outs_t obs();
    return {state_o, ir_ld_o, pc_ld_o, pc_src_o, addr_src_o, mem_rd_o, mem_wr_o,
            a_src_o, b_src_o, rf_wr_o, wd_src_o, halted_o};
  endfunction

  // Expected cycle stream for one instruction, derived from the class rules.
  task automatic build(input logic [31:0] ir, input int fw, input int mw, input logic taken);
    cyc_t c;
    logic [6:0] op = ir[6:0];
    bit ld = (op == 7'h03), stq = (op == 7'h23), br = (op == 7'h63), jl = (op == 7'h6f);
    bit jr = (op == 7'h67), lu = (op == 7'h37), au = (op == 7'h17), rr = (op == 7'h33);
    bit ia = (op == 7'h13), sy = (op == 7'h73);
    bit legal = ld | stq | br | jl | jr | lu | au | rr | ia | sy;
    exp_q.delete();
    for (int i = 0; i <= fw; i++) begin
      c = '0; c.o.st = ST_FETCH; c.o.mem_rd = 1'b1; c.rdy = (i == fw); c.o.ir_ld = c.rdy;
      exp_q.push_back(c);
    end
    c = '0; c.o.st = ST_DECODE; c.rdy = 1'($urandom); exp_q.push_back(c);
    if (!legal || (sy && ir[31:20] == 12'd1 && ir[14:12] == 3'd0)) begin
      for (int i = 0; i < 20; i++) begin
        c = '0; c.o.st = ST_HALT; c.o.halted = 1'b1; c.rdy = 1'($urandom); exp_q.push_back(c);
      end
      return;
    end
    if (!sy) begin
      c = '0; c.o.st = ST_EXEC; c.rdy = 1'($urandom);
      c.o.a_src = br | jl | au; c.o.b_src = !rr;
      if (br) begin c.o.pc_ld = 1'b1; c.o.pc_src = taken; c.ret = 1'b1; end
      exp_q.push_back(c);
      if (br) return;
    end
    if (ld | stq) begin
      for (int i = 0; i <= mw; i++) begin
        c = '0; c.o.st = ST_MEM; c.o.addr_src = 1'b1; c.o.mem_rd = ld; c.o.mem_wr = stq;
        c.rdy = (i == mw);
        if (stq && i == mw) begin c.o.pc_ld = 1'b1; c.ret = 1'b1; end
        exp_q.push_back(c);
      end
      if (stq) return;
    end
    c = '0; c.o.st = ST_WB; c.rdy = 1'($urandom); c.o.pc_ld = 1'b1; c.o.rf_wr = !sy;
    c.o.wd = ld ? 2'd1 : (jl | jr) ? 2'd2 : 2'd0; c.o.pc_src = jl | jr; c.ret = 1'b1;
    exp_q.push_back(c);
  endtask

  // Plays exp_q against the DUT; stop_at >= 0 returns before that entry.
  task automatic run_seq(input string name, input logic [31:0] ir, input logic taken, input int stop_at);
    outs_t got;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == stop_at) return;
      ir_i = ir; branch_taken_i = taken; mem_ready_i = exp_q[i].rdy;
      @(negedge clk_i);
      got = obs();
      checks++;
      if (got !== exp_q[i].o || retired_o !== exp_ret) begin
        errors++;
        $display("FAIL %s cyc%0d: got st=%0d outs=%h ret=%0d, want st=%0d outs=%h ret=%0d",
                 name, i, got.st, got, retired_o, exp_q[i].o.st, exp_q[i].o, exp_ret);
      end
      @(posedge clk_i); #1;
      if (exp_q[i].ret) exp_ret = exp_ret + 32'd1;
    end
  endtask

  task automatic test_reset();
    reset_ni = 1'b0; mem_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (obs() !== '0 || retired_o !== 32'd0) begin
      errors++; $display("FAIL reset_hold: got outs=%h ret=%0d, want 0/0", obs(), retired_o);
    end
    reset_ni = 1'b1; exp_ret = '0;
    @(negedge clk_i);
    checks++;
    if (obs() !== '0) begin
      errors++; $display("FAIL reset_first_cycle: got outs=%h, want 0", obs());
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_instr(input string name, input logic [31:0] ir, input int fw, input int mw,
                            input logic taken);
    build(ir, fw, mw, taken);
    run_seq(name, ir, taken, -1);
  endtask

  task automatic test_random(input int n);
    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h73};
    logic [31:0] ir;
    for (int k = 0; k < n; k++) begin
      ir = $urandom;
      ir[6:0] = ops[$urandom_range(0, 9)];
      if (ir[6:0] == 7'h73 && ir[31:20] == 12'd1 && ir[14:12] == 3'd0) ir[31:20] = 12'd0;
      test_instr("random", ir, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
    end
  endtask

  task automatic test_mid_reset();
    build(32'h0020A023, 0, 5, 1'b0);  // sw x2,0(x1)
    run_seq("store_pre_reset", 32'h0020A023, 1'b0, 5);
    mem_ready_i = 1'b0;
    #2;
    checks++;
    if (state_o !== ST_MEM || mem_wr_o !== 1'b1) begin
      errors++; $display("FAIL mid_reset_setup: got st=%0d wr=%b, want 4/1", state_o, mem_wr_o);
    end
    reset_ni = 1'b0;
    #1;
    checks++;
    if (obs() !== '0 || retired_o !== 32'd0) begin
      errors++; $display("FAIL mid_reset_async: got outs=%h ret=%0d, want 0/0", obs(), retired_o);
    end
    @(posedge clk_i); #1;
    reset_ni = 1'b1; exp_ret = '0;
    @(negedge clk_i);
    checks++;
    if (state_o !== ST_RESET) begin
      errors++; $display("FAIL post_reset_c1: got st=%0d, want 0", state_o);
    end
    @(posedge clk_i); #1;
    test_instr("post_reset_addi", 32'h00500093, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_instr("addi", 32'h00500093, 0, 0, 1'b0);
    test_instr("lw_wait3", 32'h0000A103, 0, 3, 1'b0);
    test_instr("beq_taken", 32'h00000463, 0, 0, 1'b1);
    test_instr("beq_not_taken", 32'h00000463, 0, 0, 1'b0);
    test_instr("jal", 32'h010000EF, 0, 0, 1'b0);
    test_instr("ecall_nop", 32'h00000073, 1, 0, 1'b0);
    test_instr("sw_fetch_wait", 32'h0020A023, 2, 1, 1'b0);
    test_random(40);
    test_mid_reset();
    test_instr("illegal_halt", 32'h0000007F, 0, 0, 1'b0);
    test_reset();
    test_instr("ebreak_halt", 32'h00100073, 1, 0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
